l2_line_fill_responder: RTL and testbench

//   AXI4 read-channel slave on the L2 side of the L1 line-fill path. Serves INCR line-fill bursts issued by L1 caches.

---
 rtl/l2_line_fill_responder.sv | 158 +++++++++++++++
 tb/tb_l2_line_fill_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_fill_responder.sv
// AXI4 read-channel slave that fetches one full L2 line and streams it back as R beats.
// Optional feature: define L2_RSP_WRAP_EN to accept WRAP (critical-word-first) bursts.
module l2_line_fill_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_SIZE  = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ID_WIDTH-1:0]      arid,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [ID_WIDTH-1:0]      rid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     line_req,
    output logic [ADDR_WIDTH-1:0]    line_addr,
    input  logic                     line_gnt,
    input  logic                     line_rvalid,
    input  logic [LINE_SIZE*8-1:0]   line_rdata,
    input  logic                     line_err,
    output logic [15:0]              err_count
);
    localparam int BEATS    = LINE_SIZE * 8 / DATA_WIDTH;
    localparam int OFF_LSB  = $clog2(DATA_WIDTH / 8);
    localparam int LINE_LSB = $clog2(LINE_SIZE);
    localparam int WIDX     = LINE_LSB - OFF_LSB;
    localparam int DW_LOG   = $clog2(DATA_WIDTH);
    localparam int BOFF_W   = $clog2(LINE_SIZE * 8);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LINE_REQ, S_LINE_WAIT, S_BURST, S_ERR_BURST
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [ID_WIDTH-1:0]            r_id;
    logic [ADDR_WIDTH-LINE_LSB-1:0] r_line_hi;
    logic [7:0]                     r_len;
    logic [7:0]                     r_cnt;
    logic [WIDX-1:0]                r_w;
    logic [1:0]                     r_rsp;
    logic [LINE_SIZE*8-1:0]         r_line;
    logic [15:0]                    r_err_count;

    logic                           w_ar_hs;
    logic                           w_r_hs;
    logic [WIDX-1:0]                w_ar_word;
    logic [WIDX-1:0]                w_w_nxt;
    logic [BOFF_W-1:0]              w_bit_off;
    logic                           w_size_ok;
    logic                           w_len_ok;
    logic                           w_incr_ok;
    logic                           w_wrap_ok;
    logic                           w_legal;

    assign w_ar_hs   = arvalid && arready;
    assign w_r_hs    = rvalid && rready;
    assign w_ar_word = araddr[LINE_LSB-1:OFF_LSB];
    assign w_size_ok = (arsize == 3'(OFF_LSB));
    assign w_len_ok  = (int'(arlen) < BEATS);
    // INCR must stay inside the fetched line: start word + arlen may not pass the last word.
    assign w_incr_ok = (arburst == 2'b01) && ((int'(arlen) + int'(w_ar_word)) < BEATS);

`ifdef L2_RSP_WRAP_EN
    logic r_wrap;
    assign w_wrap_ok = (arburst == 2'b10)
                    && (arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15)
                    && (araddr[OFF_LSB-1:0] == '0);
    assign w_w_nxt   = r_wrap ? ((r_w & ~r_len[WIDX-1:0]) | ((r_w + 1'b1) & r_len[WIDX-1:0]))
                              : (r_w + 1'b1);
`else
    logic w_unused_lsb;
    assign w_wrap_ok    = 1'b0;
    assign w_unused_lsb = ^araddr[OFF_LSB-1:0];
    assign w_w_nxt      = r_w + 1'b1;
`endif

    assign w_legal   = w_size_ok && w_len_ok && (w_incr_ok || w_wrap_ok);
    assign w_bit_off = BOFF_W'(r_w) << DW_LOG;

    // arready is gated by rst so it reads 0 for the whole reset window.
    assign arready   = (r_state == S_IDLE) && !rst;
    assign rvalid    = (r_state == S_BURST) || (r_state == S_ERR_BURST);
    assign rdata     = (r_state == S_BURST) ? r_line[w_bit_off +: DATA_WIDTH] : '0;
    assign rresp     = (r_state == S_ERR_BURST) ? RESP_SLVERR
                     : ((r_state == S_BURST) ? r_rsp : RESP_OKAY);
    assign rlast     = rvalid && (r_cnt == r_len);
    assign rid       = r_id;
    assign line_req  = (r_state == S_LINE_REQ);
    assign line_addr = {r_line_hi, {LINE_LSB{1'b0}}};
    assign err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_ar_hs) w_state_nxt = w_legal ? S_LINE_REQ : S_ERR_BURST;
            S_LINE_REQ:  if (line_gnt) w_state_nxt = S_LINE_WAIT;
            S_LINE_WAIT: if (line_rvalid) w_state_nxt = S_BURST;
            S_BURST:     if (w_r_hs && rlast) w_state_nxt = S_IDLE;
            S_ERR_BURST: if (w_r_hs && rlast) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id        <= '0;
            r_line_hi   <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_w         <= '0;
            r_rsp       <= RESP_OKAY;
            r_line      <= '0;
            r_err_count <= '0;
`ifdef L2_RSP_WRAP_EN
            r_wrap      <= 1'b0;
`endif
        end else begin
            if (w_ar_hs) begin
                r_id      <= arid;
                r_line_hi <= araddr[ADDR_WIDTH-1:LINE_LSB];
                r_len     <= arlen;
                r_cnt     <= '0;
                r_w       <= w_ar_word;
`ifdef L2_RSP_WRAP_EN
                r_wrap    <= (arburst == 2'b10);
`endif
            end
            // Only the response to our own request is taken; stray line_rvalid elsewhere is dropped.
            if (r_state == S_LINE_WAIT && line_rvalid) begin
                r_line <= line_rdata;
                r_rsp  <= line_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_r_hs) begin
                r_cnt <= r_cnt + 8'd1;
                r_w   <= w_w_nxt;
                if (rlast && rresp == RESP_SLVERR && r_err_count != 16'hFFFF)
                    r_err_count <= r_err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_l2_line_fill_responder.sv
// Bench for l2_line_fill_responder: L2 array responder, AR/R driver, line-level reference model.
// Works in both builds; the model follows L2_RSP_WRAP_EN the same way the design does.
module tb_l2_line_fill_responder;
    logic         clk;
    logic         rst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         line_req;
    logic [63:0]  line_addr;
    logic         line_gnt;
    logic         line_rvalid;
    logic [511:0] line_rdata;
    logic         line_err;
    logic [15:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;

    // L2 array behaviour knobs and the line it will return
    int           gnt_delay = 0;
    int           rv_delay  = 0;
    logic [511:0] line_mem_data = '0;
    logic         line_err_drv  = 1'b0;

    // scoreboard
    logic [63:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];
    logic        exp_legal;
    logic [15:0] exp_err = '0;

    // observations of the last burst
    logic [63:0] obs_data[$];
    logic [1:0]  obs_resp[$];
    logic        obs_last[$];
    logic [3:0]  obs_id[$];
    logic        obs_line_req;
    logic [63:0] obs_line_addr;
    int          stall_viol;
    logic        timed_out;
    int          obs_latency;
    logic        obs_arready_after;

    l2_line_fill_responder dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .line_req(line_req), .line_addr(line_addr), .line_gnt(line_gnt),
        .line_rvalid(line_rvalid), .line_rdata(line_rdata), .line_err(line_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // L2 array: grants after gnt_delay cycles of line_req, returns the line rv_delay cycles later
    initial begin
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        line_gnt = 1'b0; line_rvalid = 1'b0; line_err = 1'b0; line_rdata = '0;
        forever begin
            @(posedge clk); #1;
            line_gnt = 1'b0; line_rvalid = 1'b0; line_err = 1'b0;
            line_rdata = ~line_mem_data;
            if (st == 0) begin
                if (line_req === 1'b1) begin
                    if (cnt >= gnt_delay) begin line_gnt = 1'b1; st = 1; cnt = 0; end
                    else cnt++;
                end else cnt = 0;
            end else begin
                if (cnt >= rv_delay) begin
                    line_rvalid = 1'b1; line_rdata = line_mem_data; line_err = line_err_drv;
                    st = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: legality from the burst rules, beat words from the line by plain arithmetic
    task automatic model_burst(input logic [63:0] a, input logic [7:0] len,
                               input logic [2:0] sz, input logic [1:0] b);
        int w, n, base, word;
        w = int'(a[5:3]);
        n = int'(len) + 1;
        exp_legal = (sz == 3'd3) && (n <= 8) && (b == 2'b01) && (w + n <= 8);
`ifdef L2_RSP_WRAP_EN
        if (sz == 3'd3 && b == 2'b10 && (n == 2 || n == 4 || n == 8) && a[2:0] == 3'd0)
            exp_legal = 1'b1;
`endif
        exp_q.delete();
        exp_resp_q.delete();
        base = (w / n) * n;
        for (int i = 0; i < n; i++) begin
            if (!exp_legal) begin
                exp_q.push_back(64'd0);
                exp_resp_q.push_back(2'b10);
            end else begin
                word = (b == 2'b10) ? base + (w - base + i) % n : w + i;
                exp_q.push_back(line_mem_data[word*64 +: 64]);
                exp_resp_q.push_back(line_err_drv ? 2'b10 : 2'b00);
            end
        end
        if ((!exp_legal || line_err_drv) && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    endtask

    // Drives one AR and collects every R beat; stall_mode 0 always ready, 1 fixed pattern, 2 random
    task automatic drive_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] sz, input logic [1:0] b, input int stall_mode);
        int k, guard, p;
        logic done, holding, h_last;
        logic [63:0] h_data;
        logic [1:0] h_resp;
        logic [3:0] h_id;
        logic pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
        obs_line_req = 1'b0; obs_line_addr = '0; stall_viol = 0; timed_out = 1'b0;
        obs_latency = -1; obs_arready_after = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0;
        arid = id; araddr = addr; arlen = len; arsize = sz; arburst = b; arvalid = 1'b1;
        guard = 0;
        while (arready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) timed_out = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0; p = 0; done = 1'b0; holding = 1'b0;
        while (!done && !timed_out) begin
            if (line_req === 1'b1) begin obs_line_req = 1'b1; obs_line_addr = line_addr; end
            if (holding && (rvalid !== 1'b1 || rdata !== h_data || rresp !== h_resp ||
                            rlast !== h_last || rid !== h_id)) stall_viol++;
            holding = 1'b0;
            rready = (stall_mode == 0) ? 1'b1 :
                     (stall_mode == 1) ? pat[p % 6] : 1'($urandom_range(0, 1));
            if (rvalid === 1'b1) begin
                if (obs_latency < 0) obs_latency = k;
                p++;
                if (rready) begin
                    obs_data.push_back(rdata); obs_resp.push_back(rresp);
                    obs_last.push_back(rlast); obs_id.push_back(rid);
                    if (rlast === 1'b1) done = 1'b1;
                end else begin
                    holding = 1'b1;
                    h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
                end
            end
            @(posedge clk); #1;
            k++;
            if (k > 400) timed_out = 1'b1;
        end
        obs_arready_after = arready;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (arready !== 1'b0) $display("FAIL rst_arready: got %b exp 0", arready); else n_pass++;
        n_checks++; if ({rvalid, rlast, line_req} !== 3'b000)
            $display("FAIL rst_ctrl: got rvalid/rlast/line_req %b exp 000", {rvalid, rlast, line_req}); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL rst_err_count: got %h exp 0000", err_count); else n_pass++;
        n_checks++; if (rdata !== 64'd0 || rid !== 4'd0 || rresp !== 2'b00 || line_addr !== 64'd0)
            $display("FAIL rst_data: got rdata=%h rid=%h rresp=%b line_addr=%h exp all 0", rdata, rid, rresp, line_addr); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (arready !== 1'b1) $display("FAIL rst_release_arready: got %b exp 1", arready); else n_pass++;
        exp_err = '0;
    endtask

    task automatic test_incr_full();
        logic [3:0] id;
        id = 4'($urandom_range(0, 15));
        gnt_delay = 0; rv_delay = 0; line_err_drv = 1'b0; line_mem_data = rand_line();
        model_burst(64'h1000, 8'd7, 3'd3, 2'b01);
        drive_burst(id, 64'h1000, 8'd7, 3'd3, 2'b01, 0);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL incr_timeout: got %b exp 0", timed_out); else n_pass++;
        n_checks++; if (obs_line_addr !== 64'h1000) $display("FAIL incr_line_addr: got %h exp 1000", obs_line_addr); else n_pass++;
        n_checks++; if (obs_latency !== 2) $display("FAIL incr_latency: got %0d exp 2", obs_latency); else n_pass++;
        n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL incr_beats: got %0d exp %0d", obs_data.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1) || obs_id[i] !== id)
                $display("FAIL incr_beat%0d: got d=%h r=%b l=%b id=%h exp d=%h r=%b l=%b id=%h", i,
                         obs_data[i], obs_resp[i], obs_last[i], obs_id[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1), id);
            else n_pass++;
        end
        n_checks++; if (obs_arready_after !== 1'b1) $display("FAIL incr_arready_after: got %b exp 1", obs_arready_after); else n_pass++;
        n_checks++; if (err_count !== exp_err) $display("FAIL incr_err_count: got %h exp %h", err_count, exp_err); else n_pass++;
    endtask

    task automatic test_stall();
        gnt_delay = 2; rv_delay = 3; line_err_drv = 1'b0; line_mem_data = rand_line();
        model_burst(64'h1000, 8'd7, 3'd3, 2'b01);
        drive_burst(4'hA, 64'h1000, 8'd7, 3'd3, 2'b01, 1);
        n_checks++; if (stall_viol !== 0) $display("FAIL stall_stable: got %0d unstable cycles exp 0", stall_viol); else n_pass++;
        n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL stall_beats: got %0d exp %0d", obs_data.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1))
                $display("FAIL stall_beat%0d: got d=%h r=%b l=%b exp d=%h r=%b l=%b", i,
                         obs_data[i], obs_resp[i], obs_last[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1));
            else n_pass++;
        end
    endtask

    task automatic test_partial();
        logic [7:0] lens[2];
        lens = '{8'd3, 8'd7};
        for (int t = 0; t < 2; t++) begin
            gnt_delay = 1; rv_delay = 1; line_err_drv = 1'b0; line_mem_data = rand_line();
            model_burst(64'h1010, lens[t], 3'd3, 2'b01);
            drive_burst(4'h5, 64'h1010, lens[t], 3'd3, 2'b01, 0);
            n_checks++; if (obs_line_req !== exp_legal) $display("FAIL partial%0d_line_req: got %b exp %b", t, obs_line_req, exp_legal); else n_pass++;
            n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL partial%0d_beats: got %0d exp %0d", t, obs_data.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
                n_checks++;
                if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1))
                    $display("FAIL partial%0d_beat%0d: got d=%h r=%b l=%b exp d=%h r=%b l=%b", t, i,
                             obs_data[i], obs_resp[i], obs_last[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1));
                else n_pass++;
            end
            n_checks++; if (err_count !== exp_err) $display("FAIL partial%0d_err_count: got %h exp %h", t, err_count, exp_err); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        gnt_delay = 0; rv_delay = 2; line_err_drv = 1'b0; line_mem_data = rand_line();
        model_burst(64'h1028, 8'd7, 3'd3, 2'b10);
        drive_burst(4'h3, 64'h1028, 8'd7, 3'd3, 2'b10, 2);
        n_checks++; if (obs_line_req !== exp_legal) $display("FAIL wrap_line_req: got %b exp %b", obs_line_req, exp_legal); else n_pass++;
        n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL wrap_beats: got %0d exp %0d", obs_data.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1))
                $display("FAIL wrap_beat%0d: got d=%h r=%b l=%b exp d=%h r=%b l=%b", i,
                         obs_data[i], obs_resp[i], obs_last[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1));
            else n_pass++;
        end
        n_checks++; if (err_count !== exp_err) $display("FAIL wrap_err_count: got %h exp %h", err_count, exp_err); else n_pass++;
    endtask

    task automatic test_line_err();
        gnt_delay = 1; rv_delay = 0; line_err_drv = 1'b1; line_mem_data = rand_line();
        model_burst(64'h2000, 8'd7, 3'd3, 2'b01);
        drive_burst(4'h9, 64'h2000, 8'd7, 3'd3, 2'b01, 0);
        line_err_drv = 1'b0;
        n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL lerr_beats: got %0d exp %0d", obs_data.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1))
                $display("FAIL lerr_beat%0d: got d=%h r=%b l=%b exp d=%h r=%b l=%b", i,
                         obs_data[i], obs_resp[i], obs_last[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1));
            else n_pass++;
        end
        n_checks++; if (err_count !== exp_err) $display("FAIL lerr_err_count: got %h exp %h", err_count, exp_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hs, cyc, bad;
        // reset after the third beat handshake
        gnt_delay = 0; rv_delay = 0; line_err_drv = 1'b0; line_mem_data = rand_line();
        arid = 4'h6; araddr = 64'h1000; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 50) begin
            if (rvalid === 1'b1) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (hs !== 3) $display("FAIL rmid_beats_before_rst: got %0d exp 3", hs); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rvalid !== 1'b0) $display("FAIL rmid_rvalid: got %b exp 0", rvalid); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (arready !== 1'b1) $display("FAIL rmid_arready: got %b exp 1", arready); else n_pass++;
        rready = 1'b0;
        exp_err = '0;
        // reset while the line read is outstanding; the late line_rvalid must be ignored
        gnt_delay = 0; rv_delay = 8;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid !== 1'b0 || line_req !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad !== 0) $display("FAIL rline_late_rvalid: got %0d active cycles exp 0", bad); else n_pass++;
        gnt_delay = 1; rv_delay = 1; line_mem_data = rand_line();
        model_burst(64'h3000, 8'd7, 3'd3, 2'b01);
        drive_burst(4'h2, 64'h3000, 8'd7, 3'd3, 2'b01, 0);
        n_checks++; if (obs_data.size() !== exp_q.size()) $display("FAIL rnext_beats: got %0d exp %0d", obs_data.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1))
                $display("FAIL rnext_beat%0d: got d=%h r=%b l=%b exp d=%h r=%b l=%b", i,
                         obs_data[i], obs_resp[i], obs_last[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1));
            else n_pass++;
        end
        n_checks++; if (err_count !== exp_err) $display("FAIL rnext_err_count: got %h exp %h", err_count, exp_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  b;
        logic [3:0]  id;
        for (int t = 0; t < 40; t++) begin
            a   = {48'h0, 10'($urandom_range(0, 1023)), 6'($urandom_range(0, 63))};
            len = 8'($urandom_range(0, 9));
            sz  = ($urandom_range(0, 4) == 0) ? 3'd2 : 3'd3;
            b   = 2'($urandom_range(0, 3));
            id  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            gnt_delay = $urandom_range(0, 3); rv_delay = $urandom_range(0, 4);
            line_err_drv = ($urandom_range(0, 7) == 0);
            line_mem_data = rand_line();
            model_burst(a, len, sz, b);
            drive_burst(id, a, len, sz, b, $urandom_range(0, 2));
            n_checks++;
            if (timed_out !== 1'b0 || stall_viol !== 0 || obs_line_req !== exp_legal || obs_data.size() !== exp_q.size())
                $display("FAIL rnd%0d_burst: got to=%b unstable=%0d line_req=%b beats=%0d exp to=0 unstable=0 line_req=%b beats=%0d",
                         t, timed_out, stall_viol, obs_line_req, obs_data.size(), exp_legal, exp_q.size());
            else n_pass++;
            if (exp_legal) begin
                n_checks++;
                if (obs_line_addr !== {a[63:6], 6'd0}) $display("FAIL rnd%0d_line_addr: got %h exp %h", t, obs_line_addr, {a[63:6], 6'd0}); else n_pass++;
            end
            for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
                n_checks++;
                if (obs_data[i] !== exp_q[i] || obs_resp[i] !== exp_resp_q[i] || obs_last[i] !== (i == exp_q.size() - 1) || obs_id[i] !== id)
                    $display("FAIL rnd%0d_beat%0d: got d=%h r=%b l=%b id=%h exp d=%h r=%b l=%b id=%h", t, i,
                             obs_data[i], obs_resp[i], obs_last[i], obs_id[i], exp_q[i], exp_resp_q[i], (i == exp_q.size() - 1), id);
                else n_pass++;
            end
            n_checks++; if (err_count !== exp_err) $display("FAIL rnd%0d_err_count: got %h exp %h", t, err_count, exp_err); else n_pass++;
        end
        line_err_drv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_incr_full();
        test_stall();
        test_partial();
        test_wrap();
        test_line_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
